sos_panel: RTL and testbench

- Operator-side end of the SOS flip/mode interface in the elevator controller.
- Synchronises and debounces the raw cabin SOS button, then emits a single-cycle sos_flip pulse toward the SOS handler.
- Checks that the handler's sos_mode actually toggles in response, and drives a blinking alarm LED while sos_mode is high.
- Sits between the cabin panel I/O and the SOS handler.

---
 rtl/sos_pkg.sv | 34 +++
 rtl/sos_sync2.sv | 34 +++
 rtl/sos_panel.sv | 193 +++++++++++++++++++
 tb/tb_sos_panel.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sos_pkg.sv
// -----------------------------------------------------------------------------
// sos_pkg
// Shared definitions for the cabin-side SOS panel logic: the button/ack FSM
// state encoding, default timing parameters and a small helper used to size
// the shared FSM counter.
// -----------------------------------------------------------------------------
package sos_pkg;

  // Default timing, all in clk cycles.
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int ACK_TIMEOUT_DEF     = 8;
  localparam int LOCKOUT_CYCLES_DEF  = 16;
  localparam int BLINK_HALF_DEF      = 4;

  // Button / acknowledge sequencing states.
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    DEBOUNCE     = 3'd1,
    FLIP         = 3'd2,
    WAIT_ACK     = 3'd3,
    LOCKOUT      = 3'd4,
    WAIT_RELEASE = 3'd5
  } sos_state_t;

  // Largest of three values; sizes the counter shared by several states.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sos_sync2.sv
// -----------------------------------------------------------------------------
// sos_sync2
// Two-flop synchroniser for a single asynchronous level. Both stages reset to
// RESET_VAL so the synchronised output comes out of reset at a known level.
//
// Ports:
//   clk  - sampling clock
//   rst  - asynchronous active-high reset
//   d    - asynchronous input level
//   q    - synchronised level (second stage)
// -----------------------------------------------------------------------------
module sos_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic stage1;

  // Plain two-stage shift; the first stage is allowed to go metastable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage1 <= RESET_VAL;
      q      <= RESET_VAL;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// File: rtl/sos_panel.sv
// -----------------------------------------------------------------------------
// sos_panel
// Operator-side end of the SOS flip/mode interface. The raw cabin button is
// synchronised and debounced, then a single-cycle sos_flip pulse is sent to
// the SOS handler. The panel then watches sos_mode to confirm the handler
// toggled, raising a sticky ack_fault if it did not. Independently, the
// alarm LED blinks whenever sos_mode is high.
//
// Ports:
//   clk       - single clock, rising edge
//   rst       - asynchronous active-high reset
//   btn_raw   - raw SOS button, asynchronous and bouncy
//   sos_mode  - SOS mode level from the handler (clk domain)
//   fault_clr - one-cycle clear of ack_fault
//   sos_flip  - one-cycle toggle request to the handler
//   alarm_led - blinking indicator while sos_mode is high
//   ack_fault - sticky: a flip was sent but sos_mode never changed
//   busy      - high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module sos_panel
  import sos_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int ACK_TIMEOUT     = ACK_TIMEOUT_DEF,
  parameter int LOCKOUT_CYCLES  = LOCKOUT_CYCLES_DEF,
  parameter int BLINK_HALF      = BLINK_HALF_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic sos_mode,
  input  logic fault_clr,
  output logic sos_flip,
  output logic alarm_led,
  output logic ack_fault,
  output logic busy
);

  localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, ACK_TIMEOUT, LOCKOUT_CYCLES);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = $clog2(BLINK_HALF + 1);

  // Terminal counts; every one of them resets the counter, so it never wraps.
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ACK_LAST   = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCKOUT_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  sos_state_t    state;
  sos_state_t    state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          btn_s;
  logic          mode_before;
  logic          capture_mode;
  logic          fault_set;
  logic          mode_q;
  logic [BW-1:0] blink_cnt;

  // The synchroniser resets high: a button held through reset looks pressed,
  // which parks the FSM in WAIT_RELEASE until it is actually let go.
  sos_sync2 #(
    .RESET_VAL(1'b1)
  ) u_btn_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (btn_s)
  );

  // State register plus the shared counter and the pre-flip mode snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_RELEASE;
      cnt         <= '0;
      mode_before <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (capture_mode) begin
        mode_before <= sos_mode;
      end
    end
  end

  // Next-state logic. The counter is reused by DEBOUNCE, WAIT_ACK and
  // LOCKOUT and is cleared whenever one of those states is entered or left.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    capture_mode = 1'b0;
    fault_set    = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_next = DEBOUNCE;
          cnt_next   = '0;
        end
      end
      DEBOUNCE: begin
        if (!btn_s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == DEB_LAST) begin
          state_next   = FLIP;
          cnt_next     = '0;
          capture_mode = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      FLIP: begin
        state_next = WAIT_ACK;
        cnt_next   = '0;
      end
      WAIT_ACK: begin
        if (sos_mode != mode_before) begin
          state_next = LOCKOUT;
          cnt_next   = '0;
        end else if (cnt == ACK_LAST) begin
          fault_set  = 1'b1;
          state_next = LOCKOUT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      LOCKOUT: begin
        if (cnt == LOCK_LAST) begin
          state_next = WAIT_RELEASE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      WAIT_RELEASE: begin
        if (!btn_s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = WAIT_RELEASE;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs decoded straight from the state register, so sos_flip lasts
  // exactly the one cycle spent in FLIP.
  always_comb begin
    sos_flip = (state == FLIP);
    busy     = (state != IDLE);
  end

  // Sticky acknowledge fault. A new fault beats a coincident clear so that a
  // failure can never be silently lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_fault <= 1'b0;
    end else if (fault_set) begin
      ack_fault <= 1'b1;
    end else if (fault_clr) begin
      ack_fault <= 1'b0;
    end
  end

  // Alarm LED, independent of the button FSM. It lights immediately on the
  // rising edge of sos_mode, then toggles every BLINK_HALF cycles, and is
  // forced dark as soon as sos_mode drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= 1'b0;
      alarm_led <= 1'b0;
      blink_cnt <= '0;
    end else begin
      mode_q <= sos_mode;
      if (!sos_mode) begin
        alarm_led <= 1'b0;
        blink_cnt <= '0;
      end else if (!mode_q) begin
        alarm_led <= 1'b1;
        blink_cnt <= '0;
      end else if (blink_cnt == BLINK_LAST) begin
        alarm_led <= ~alarm_led;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sos_panel.sv
// -----------------------------------------------------------------------------
// tb_sos_panel
// Directed self-checking bench for sos_panel with default parameters
// (DEBOUNCE 4, ACK_TIMEOUT 8, LOCKOUT 16, BLINK_HALF 4). A tiny handler model
// toggles sos_mode one edge after it sees sos_flip, when enabled.
// -----------------------------------------------------------------------------
module tb_sos_panel;

  logic clk;
  logic rst;
  logic btn_raw;
  logic sos_mode;
  logic fault_clr;
  logic sos_flip;
  logic alarm_led;
  logic ack_fault;
  logic busy;

  logic hand_en;
  int   checks;
  int   failures;

  sos_panel dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .sos_mode  (sos_mode),
    .fault_clr (fault_clr),
    .sos_flip  (sos_flip),
    .alarm_led (alarm_led),
    .ack_fault (ack_fault),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the button and clear inputs, advance one rising edge, and settle
  // 1 time unit past it. The handler model answers a flip seen during the
  // cycle by toggling sos_mode just after the following edge.
  task automatic applyStimulus(input logic b, input logic c);
    logic pf;
    btn_raw   = b;
    fault_clr = c;
    pf        = sos_flip;
    @(posedge clk);
    #1;
    if (hand_en && pf) sos_mode = ~sos_mode;
  endtask

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%b expected=%b at %0t", tag, act, exp, $time);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    btn_raw   = 1'b0;
    sos_mode  = 1'b0;
    fault_clr = 1'b0;
    hand_en   = 1'b0;

    // Reset values.
    #12;
    checkOutput("rst_flip", sos_flip, 1'b0);
    checkOutput("rst_led", alarm_led, 1'b0);
    checkOutput("rst_fault", ack_fault, 1'b0);
    checkOutput("rst_busy", busy, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Synchroniser drains its reset 1s, then WAIT_RELEASE -> IDLE.
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("init_busy_hold", busy, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("init_idle", busy, 1'b0);

    // Press held: flip appears only after edge k+6, handler toggles.
    $display("[TB] held press with acknowledging handler");
    hand_en = 1'b1;
    for (int i = 0; i <= 7; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("flip_latency", sos_flip, (i == 6));
    end
    checkOutput("handler_toggled", sos_mode, 1'b1);
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("held_no_reflip", sos_flip, 1'b0);
    end
    checkOutput("ack_ok_no_fault", ack_fault, 1'b0);
    checkOutput("held_busy", busy, 1'b1);
    hand_en = 1'b0;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("release_busy", busy, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("release_idle", busy, 1'b0);

    sos_mode = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0);

    // Bounce: three 2-cycle highs split by single lows, then quiet.
    $display("[TB] bounce rejection");
    for (int i = 0; i <= 12; i++) begin
      applyStimulus((i < 8) && (i % 3 != 2), 1'b0);
      checkOutput("bounce_flip", sos_flip, 1'b0);
      checkOutput("bounce_busy", busy, (i >= 2) && (i <= 10) && ((i - 2) % 3 != 2));
    end

    // Handler silent: fault 8 edges after entering WAIT_ACK (edge k+15).
    $display("[TB] ack timeout");
    for (int i = 0; i <= 16; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("timeout_fault", ack_fault, (i >= 15));
    end
    applyStimulus(1'b1, 1'b1);
    checkOutput("fault_cleared", ack_fault, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("timeout_idle", busy, 1'b0);

    // Fault set coincident with fault_clr: set wins.
    for (int i = 0; i <= 15; i++) begin
      applyStimulus(1'b1, (i == 15));
      if (i == 14) checkOutput("coinc_before", ack_fault, 1'b0);
    end
    checkOutput("coinc_set_wins", ack_fault, 1'b1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("coinc_sticky", ack_fault, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("coinc_clear", ack_fault, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);

    // Alarm LED blink: 1 for edges 1-4, 0 for 5-8, ...
    $display("[TB] alarm blink");
    sos_mode = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("blink", alarm_led, (((i - 1) / 4) % 2 == 0));
      checkOutput("blink_no_flip", sos_flip, 1'b0);
    end
    sos_mode = 1'b0;
    applyStimulus(1'b0, 1'b0);
    checkOutput("blink_off", alarm_led, 1'b0);

    // Button held across reset: no flip until released and pressed again.
    $display("[TB] button held across reset");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_flip", sos_flip, 1'b0);
    checkOutput("midrst_busy", busy, 1'b1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("heldrst_no_flip", sos_flip, 1'b0);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("heldrst_idle", busy, 1'b0);
    for (int i = 0; i <= 9; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("repress_flip", sos_flip, (i == 6));
    end

    // Reset during WAIT_ACK aborts with no fault.
    rst = 1'b1;
    #1;
    checkOutput("ackrst_flip", sos_flip, 1'b0);
    checkOutput("ackrst_fault", ack_fault, 1'b0);
    checkOutput("ackrst_led", alarm_led, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("ackrst_no_flip", sos_flip, 1'b0);
    end
    checkOutput("ackrst_no_fault", ack_fault, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("final_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
